// File: rtl/output_mem_pkg.sv
// Shared constants and types for the output_mem stream capture buffer.
// Holds FSM state codes, register-page offsets, page decode helpers and
// the AXI-Stream beat payload type.
package output_mem_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned KEEP_W  = DATA_W / 8;
    localparam int unsigned APB_AW  = 32;
    localparam int unsigned OFF_W   = 12;
    localparam int unsigned PAGE_W  = APB_AW - OFF_W;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE    = 2'd2;

    localparam logic [OFF_W-1:0] OFF_STATUS  = 12'h000;
    localparam logic [OFF_W-1:0] OFF_LENGTH  = 12'h004;
    localparam logic [OFF_W-1:0] OFF_CONTROL = 12'h008;

    localparam logic [PAGE_W-1:0] BASE_ADDR_DEF = 20'h43C10;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } axis_beat_t;

    // The register page sits directly above the RAM window.
    function automatic logic [PAGE_W-1:0] reg_page(input logic [PAGE_W-1:0] base);
        return base + PAGE_W'(1);
    endfunction

endpackage

// File: rtl/output_mem_ram.sv
// Simple dual-port capture RAM: one write port with byte enables and one
// synchronous read port. Reads return the old word on a same-address
// collision with a write (read-first).
// Ports:
//   clk    clock
//   we     write enable
//   be     per-byte write enables
//   waddr  write word address
//   wdata  write data
//   raddr  read word address, sampled every cycle
//   rdata  registered read data
module output_mem_ram
    import output_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [KEEP_W-1:0] be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array and read register.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        if (we) begin
            for (int i = 0; i < int'(KEEP_W); i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/output_mem.sv
// Stream-to-memory capture buffer. A rising edge on Capture_start arms the
// capture of one AXI-Stream packet into on-chip RAM; the processor reads the
// data and status back over APB.
// Optional feature: define OUTMEM_BYTE_MASK_EN to let tkeep gate byte writes.
// Ports:
//   S_APB_aclk / S_APB_areset   clock, synchronous active-high reset
//   S_APB_p*                    APB slave (one wait state per access)
//   Capture_start, Busy         capture arm level input, capture-active flag
//   S_AXIS_t*                   AXI-Stream sink
// APB map: RAM window at BASE_ADDR page, registers at BASE_ADDR+1 page:
//   0x000 STATUS {Ovf,Done,Busy}, 0x004 LENGTH, 0x008 CONTROL (bit0 clears).
module output_mem
    import output_mem_pkg::*;
#(
    parameter int unsigned      ADDR_W    = 10,
    parameter logic [PAGE_W-1:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic              S_APB_aclk,
    input  logic              S_APB_areset,
    input  logic [APB_AW-1:0] S_APB_paddr,
    input  logic              S_APB_psel,
    input  logic              S_APB_penable,
    input  logic              S_APB_pwrite,
    input  logic [DATA_W-1:0] S_APB_pwdata,
    output logic [DATA_W-1:0] S_APB_prdata,
    output logic              S_APB_pready,
    output logic              S_APB_pslverr,
    input  logic              Capture_start,
    output logic              Busy,
    input  logic [DATA_W-1:0] S_AXIS_tdata,
    input  logic [KEEP_W-1:0] S_AXIS_tkeep,
    input  logic              S_AXIS_tvalid,
    input  logic              S_AXIS_tlast,
    output logic              S_AXIS_tready
);

    localparam int unsigned       CNT_W    = ADDR_W + 1;
    localparam logic [PAGE_W-1:0] REG_PAGE = reg_page(BASE_ADDR);

    logic [STATE_W-1:0] state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               done, done_nxt;
    logic               ovf, ovf_nxt;
    logic               start_q0, start_q1;
    logic               capturing;

    logic               arm_c, beat_c, access_c, clear_c, ram_we_c;
    logic               ram_page_c, reg_page_c, err_c;
    logic [OFF_W-1:0]   offset_c;
    logic [KEEP_W-1:0]  ram_be_c;
    logic [DATA_W-1:0]  ram_rdata, rdata_c;
    axis_beat_t         beat_in;
    logic               unused_c;

    assign beat_in    = '{data: S_AXIS_tdata, keep: S_AXIS_tkeep, last: S_AXIS_tlast};
    assign arm_c      = ({start_q1, start_q0} == 2'b01);
    assign beat_c     = S_AXIS_tvalid & capturing;
    assign access_c   = S_APB_psel & S_APB_penable & ~S_APB_pready;
    assign offset_c   = S_APB_paddr[OFF_W-1:0];
    assign ram_page_c = (S_APB_paddr[APB_AW-1:OFF_W] == BASE_ADDR);
    assign reg_page_c = (S_APB_paddr[APB_AW-1:OFF_W] == REG_PAGE);
    assign clear_c    = access_c & S_APB_pwrite & reg_page_c
                      & (offset_c == OFF_CONTROL) & S_APB_pwdata[0];

    // cnt doubles as write address and Length; its MSB marks a full buffer.
    assign ram_we_c   = beat_c & ~cnt[ADDR_W] & ~clear_c & ~S_APB_areset;

`ifdef OUTMEM_BYTE_MASK_EN
    assign ram_be_c = beat_in.keep;
    assign unused_c = ^{S_APB_pwdata[DATA_W-1:1], beat_in.last};
`else
    assign ram_be_c = '1;
    assign unused_c = ^{S_APB_pwdata[DATA_W-1:1], beat_in.keep, beat_in.last};
`endif

    assign S_AXIS_tready = capturing;
    assign Busy          = capturing;

    // Capture RAM; read address follows paddr so data is ready for the access phase.
    output_mem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (S_APB_aclk),
        .we    (ram_we_c),
        .be    (ram_be_c),
        .waddr (cnt[ADDR_W-1:0]),
        .wdata (beat_in.data),
        .raddr (S_APB_paddr[ADDR_W+1:2]),
        .rdata (ram_rdata)
    );

    // Capture FSM next-state; a CONTROL clear overrides beats and arms.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = done;
        ovf_nxt   = ovf;
        if (clear_c) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm_c) begin
                        state_nxt = ST_CAPTURE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b0;
                        ovf_nxt   = 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (beat_c) begin
                        if (!cnt[ADDR_W]) begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                        if (beat_in.last) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Capture state registers and Capture_start edge detector.
    always_ff @(posedge S_APB_aclk) begin
        if (S_APB_areset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            capturing <= 1'b0;
            start_q0  <= 1'b0;
            start_q1  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            done      <= done_nxt;
            ovf       <= ovf_nxt;
            capturing <= (state_nxt == ST_CAPTURE);
            start_q0  <= Capture_start;
            start_q1  <= start_q0;
        end
    end

    // APB read mux and address decode.
    always_comb begin
        rdata_c = '0;
        err_c   = 1'b1;
        if (ram_page_c) begin
            rdata_c = ram_rdata;
            err_c   = 1'b0;
        end else if (reg_page_c) begin
            case (offset_c)
                OFF_STATUS: begin
                    rdata_c = {{(DATA_W-3){1'b0}}, ovf, done, capturing};
                    err_c   = 1'b0;
                end
                OFF_LENGTH: begin
                    rdata_c = DATA_W'(cnt);
                    err_c   = 1'b0;
                end
                OFF_CONTROL: err_c = 1'b0;
                default:     err_c = 1'b1;
            endcase
        end
    end

    // APB response: one wait state, data and error qualified by pready.
    always_ff @(posedge S_APB_aclk) begin
        if (S_APB_areset) begin
            S_APB_pready  <= 1'b0;
            S_APB_prdata  <= '0;
            S_APB_pslverr <= 1'b0;
        end else begin
            S_APB_pready <= access_c;
            if (access_c) begin
                S_APB_prdata  <= err_c ? '0 : rdata_c;
                S_APB_pslverr <= err_c;
            end else begin
                S_APB_prdata  <= '0;
                S_APB_pslverr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_mem.sv
// Directed self-checking bench for output_mem.
module tb_output_mem;

    localparam logic [31:0] RAM_BASE = 32'h43C1_0000;
    localparam logic [31:0] REG_BASE = 32'h43C1_1000;

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        cap_start, busy;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tlast, tready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_mem dut (
        .S_APB_aclk    (clk),
        .S_APB_areset  (areset),
        .S_APB_paddr   (paddr),
        .S_APB_psel    (psel),
        .S_APB_penable (penable),
        .S_APB_pwrite  (pwrite),
        .S_APB_pwdata  (pwdata),
        .S_APB_prdata  (prdata),
        .S_APB_pready  (pready),
        .S_APB_pslverr (pslverr),
        .Capture_start (cap_start),
        .Busy          (busy),
        .S_AXIS_tdata  (tdata),
        .S_AXIS_tkeep  (tkeep),
        .S_AXIS_tvalid (tvalid),
        .S_AXIS_tlast  (tlast),
        .S_AXIS_tready (tready)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clk);
        penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pready && n < 8);
        check("apb_pready", 32'(pready), 32'd1);
        rdata = prdata;
        err   = pslverr;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b0, addr, 32'd0, rd, err);
        check(tag, rd, exp);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic apb_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, addr, data, rd, err);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic arm();
        @(negedge clk);
        cap_start = 1'b1;
        repeat (3) @(negedge clk);
        cap_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        while (!tready && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (!tready) check("tready_timeout", 32'(tready), 32'd1);
        tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] exp_mask;

        areset = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = '0; cap_start = 1'b0; tdata = '0; tkeep = 4'hF; tvalid = 1'b0; tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tready",  32'(tready),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_pready",  32'(pready),  32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata",  prdata,       32'd0);
        areset = 1'b0;
        check_read("rst_status", REG_BASE + 32'h0, 32'd0);
        check_read("rst_length", REG_BASE + 32'h4, 32'd0);

        // Basic 4-beat packet.
        arm();
        check("arm_busy",   32'(busy),   32'd1);
        check("arm_tready", 32'(tready), 32'd1);
        for (int i = 1; i <= 4; i++) send_beat(32'(i * 32'h11), 4'hF, i == 4);
        check("pkt4_tready", 32'(tready), 32'd0);
        check("pkt4_busy",   32'(busy),   32'd0);
        check_read("pkt4_status", REG_BASE + 32'h0, 32'h2);
        check_read("pkt4_length", REG_BASE + 32'h4, 32'd4);
        for (int i = 0; i < 4; i++) check_read("pkt4_ram", RAM_BASE + 32'(4 * i), 32'((i + 1) * 32'h11));

        // Overflow: 1030 beats into a 1024-word buffer.
        arm();
        for (int k = 1; k <= 1030; k++) send_beat(32'hC000_0000 | 32'(k), 4'hF, k == 1030);
        check_read("ovf_length", REG_BASE + 32'h4, 32'd1024);
        check_read("ovf_status", REG_BASE + 32'h0, 32'h6);
        check_read("ovf_ram0",    RAM_BASE,             32'hC000_0001);
        check_read("ovf_ram1023", RAM_BASE + 32'd4092,  32'hC000_0400);

        // Re-arm clears Ovf; an arm during capture is ignored.
        arm();
        send_beat(32'hD1, 4'hF, 1'b0);
        send_beat(32'hD2, 4'hF, 1'b0);
        check_read("cap_status", REG_BASE + 32'h0, 32'h1);
        arm();
        send_beat(32'hD3, 4'hF, 1'b1);
        check_read("rearm_length", REG_BASE + 32'h4, 32'd3);
        check_read("rearm_status", REG_BASE + 32'h0, 32'h2);
        check_read("rearm_ram2",   RAM_BASE + 32'd8, 32'hD3);

        // RAM window is read-only from APB.
        apb_write("ramwr", RAM_BASE, 32'hFFFF_FFFF);
        check_read("ramwr_ignored", RAM_BASE, 32'hD1);

        // Byte qualifiers.
        arm();
        send_beat(32'hAAAA_AAAA, 4'hF, 1'b1);
        arm();
        send_beat(32'h1234_5678, 4'b0101, 1'b1);
`ifdef OUTMEM_BYTE_MASK_EN
        exp_mask = 32'hAA34_AA78;
`else
        exp_mask = 32'h1234_5678;
`endif
        check_read("keep_ram0", RAM_BASE, exp_mask);

        // CONTROL clear mid-capture with tvalid held high.
        arm();
        send_beat(32'h91, 4'hF, 1'b0);
        send_beat(32'h92, 4'hF, 1'b0);
        tdata = 32'h99; tkeep = 4'hF; tlast = 1'b0; tvalid = 1'b1;
        apb_write("clear", REG_BASE + 32'h8, 32'd1);
        check("clear_tready", 32'(tready), 32'd0);
        check("clear_busy",   32'(busy),   32'd0);
        tvalid = 1'b0;
        check_read("clear_length", REG_BASE + 32'h4, 32'd0);
        check_read("clear_status", REG_BASE + 32'h0, 32'd0);

        // Unmapped addresses.
        apb_xfer(1'b0, REG_BASE + 32'hC, 32'd0, rd, err);
        check("err_pslverr", 32'(err), 32'd1);
        check("err_prdata",  rd,       32'd0);
        @(negedge clk);
        check("err_pready_pulse", 32'(pready), 32'd0);
        apb_xfer(1'b0, 32'h1000_0000, 32'd0, rd, err);
        check("err_page_pslverr", 32'(err), 32'd1);

        // Reset during capture, then re-arm.
        arm();
        send_beat(32'h77, 4'hF, 1'b0);
        areset = 1'b1;
        @(negedge clk);
        check("rstcap_tready", 32'(tready), 32'd0);
        check("rstcap_busy",   32'(busy),   32'd0);
        areset = 1'b0;
        check_read("rstcap_status", REG_BASE + 32'h0, 32'd0);
        check_read("rstcap_length", REG_BASE + 32'h4, 32'd0);
        arm();
        send_beat(32'h5555, 4'hF, 1'b1);
        check_read("rstcap_rearm_len", REG_BASE + 32'h4, 32'd1);
        check_read("rstcap_rearm_ram", RAM_BASE, 32'h5555);
        check_read("rstcap_rearm_st",  REG_BASE + 32'h0, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
